decode: RTL and testbench

Instruction-decode stage of the 5-stage pipeline, directly downstream of `fetch`. It consumes the IF/ID bundle (`instr_IFID`, `PC_IFID`, `PC2_IFID`, `halt_IFID`) and contains the 8×16 register file with write-before-read bypass. It decodes register fields and immediates, detects load-use hazards, and drives `stallCtrl`/`startStall` back to fetch. It registers everything into the ID/EX bundle with one cycle of latency.

---
 rtl/decode_if.sv | 45 ++++
 rtl/decode.sv | 175 +++++++++++++++++
 tb/tb_decode.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/decode_if.sv
// Signal bundle between fetch/EX-MEM/WB and the decode stage.
// master = environment driving IF/ID, flush, freeze and write-back; slave = decode.
interface decode_if;
  // Flow control: freeze=1 lets every stage register advance on the edge.
  // stallCtrl=1 means decode refuses the IF/ID instruction this cycle and fetch must hold it.
  logic [15:0] instr_IFID;
  logic [15:0] PC_IFID;
  logic [15:0] PC2_IFID;
  logic        halt_IFID;
  logic        takeBranch_EXMEM;
  logic        freeze;
  logic        wbEn;
  logic [2:0]  wbReg;
  logic [15:0] wbData;

  logic        stallCtrl;
  logic        startStall;
  logic [15:0] PC_IDEX;
  logic [15:0] PC2_IDEX;
  logic [15:0] rsData_IDEX;
  logic [15:0] rtData_IDEX;
  logic [15:0] imm_IDEX;
  logic [4:0]  opcode_IDEX;
  logic [2:0]  writeReg_IDEX;
  logic        regWrite_IDEX;
  logic        memRead_IDEX;
  logic        memWrite_IDEX;
  logic        halt_IDEX;

  modport master (
    output instr_IFID, PC_IFID, PC2_IFID, halt_IFID, takeBranch_EXMEM, freeze,
           wbEn, wbReg, wbData,
    input  stallCtrl, startStall, PC_IDEX, PC2_IDEX, rsData_IDEX, rtData_IDEX,
           imm_IDEX, opcode_IDEX, writeReg_IDEX, regWrite_IDEX, memRead_IDEX,
           memWrite_IDEX, halt_IDEX
  );

  modport slave (
    input  instr_IFID, PC_IFID, PC2_IFID, halt_IFID, takeBranch_EXMEM, freeze,
           wbEn, wbReg, wbData,
    output stallCtrl, startStall, PC_IDEX, PC2_IDEX, rsData_IDEX, rtData_IDEX,
           imm_IDEX, opcode_IDEX, writeReg_IDEX, regWrite_IDEX, memRead_IDEX,
           memWrite_IDEX, halt_IDEX
  );
endinterface

// File: rtl/decode.sv
// Instruction-decode stage: register file with write-back bypass, field/immediate
// decode, load-use hazard detection and the ID/EX pipeline register.
module decode (
  input  logic     clk,
  input  logic     rst,
  decode_if.slave  bus
);

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] pc2;
    logic [15:0] rs_data;
    logic [15:0] rt_data;
    logic [15:0] imm;
    logic [4:0]  opcode;
    logic [2:0]  write_reg;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        halt;
  } idex_t;

  localparam idex_t BUBBLE = '{
    pc:        16'h0000,
    pc2:       16'h0000,
    rs_data:   16'h0000,
    rt_data:   16'h0000,
    imm:       16'h0000,
    opcode:    5'b00001,
    write_reg: 3'd0,
    reg_write: 1'b0,
    mem_read:  1'b0,
    mem_write: 1'b0,
    halt:      1'b0
  };

  idex_t       idex_q, idex_d;
  logic        stall_q, stall_d;
  logic [15:0] rf_q [8];

  logic [4:0]  op;
  logic [2:0]  rs, rt, rd;
  logic [2:0]  dest;
  logic        reg_write, mem_read, mem_write;
  logic        uses_rs, uses_rt;
  logic [15:0] imm;
  logic [15:0] rs_data, rt_data;
  logic        load_use;
  logic        stall;

  assign op = bus.instr_IFID[15:11];
  assign rs = bus.instr_IFID[10:8];
  assign rt = bus.instr_IFID[7:5];
  assign rd = bus.instr_IFID[4:2];

  always_comb begin
    dest      = 3'd0;
    reg_write = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    uses_rs   = 1'b0;
    uses_rt   = 1'b0;
    imm       = 16'h0000;
    casez (op)
      5'b1101?: begin
        dest      = rd;
        reg_write = 1'b1;
        uses_rs   = 1'b1;
        uses_rt   = 1'b1;
      end
      5'b010??, 5'b101??, 5'b10001: begin
        dest      = rt;
        reg_write = 1'b1;
        uses_rs   = 1'b1;
        mem_read  = (op == 5'b10001);
        // Logical immediates (01010/01011) take an unsigned 5-bit operand.
        if (op == 5'b01010 || op == 5'b01011)
          imm = {11'h000, bus.instr_IFID[4:0]};
        else
          imm = {{11{bus.instr_IFID[4]}}, bus.instr_IFID[4:0]};
      end
      5'b10000: begin
        uses_rs   = 1'b1;
        uses_rt   = 1'b1;
        mem_write = 1'b1;
        imm       = {{11{bus.instr_IFID[4]}}, bus.instr_IFID[4:0]};
      end
      5'b011??: begin
        uses_rs = 1'b1;
        imm     = {{8{bus.instr_IFID[7]}}, bus.instr_IFID[7:0]};
      end
      5'b11000: begin
        dest      = rs;
        reg_write = 1'b1;
        imm       = {{8{bus.instr_IFID[7]}}, bus.instr_IFID[7:0]};
      end
      5'b00100: begin
        imm = {{5{bus.instr_IFID[10]}}, bus.instr_IFID[10:0]};
      end
      5'b00110: begin
        dest      = 3'd7;
        reg_write = 1'b1;
        imm       = {{5{bus.instr_IFID[10]}}, bus.instr_IFID[10:0]};
      end
      default: ;
    endcase
  end

  // Write-before-read: a same-cycle write-back is visible to the reader.
  assign rs_data = (bus.wbEn && bus.wbReg == rs) ? bus.wbData : rf_q[rs];
  assign rt_data = (bus.wbEn && bus.wbReg == rt) ? bus.wbData : rf_q[rt];

  assign load_use = idex_q.mem_read &
                    (((idex_q.write_reg == rs) & uses_rs) |
                     ((idex_q.write_reg == rt) & uses_rt));
  assign stall    = load_use & ~bus.takeBranch_EXMEM;

  assign bus.stallCtrl  = stall;
  assign bus.startStall = stall & ~stall_q;

  always_comb begin
    idex_d  = idex_q;
    stall_d = stall_q;
    if (bus.freeze) begin
      stall_d = stall;
      if (bus.takeBranch_EXMEM || stall) begin
        idex_d = BUBBLE;
      end else begin
        idex_d.pc        = bus.PC_IFID;
        idex_d.pc2       = bus.PC2_IFID;
        idex_d.rs_data   = rs_data;
        idex_d.rt_data   = rt_data;
        idex_d.imm       = imm;
        idex_d.opcode    = op;
        idex_d.write_reg = dest;
        idex_d.reg_write = reg_write;
        idex_d.mem_read  = mem_read;
        idex_d.mem_write = mem_write;
        idex_d.halt      = bus.halt_IFID;
      end
    end
  end

  // Reset wins over freeze so a frozen pipeline can still be cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      idex_q  <= BUBBLE;
      stall_q <= 1'b0;
    end else begin
      idex_q  <= idex_d;
      stall_q <= stall_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) rf_q[i] <= 16'h0000;
    end else if (bus.wbEn && bus.freeze) begin
      rf_q[bus.wbReg] <= bus.wbData;
    end
  end

  assign bus.PC_IDEX       = idex_q.pc;
  assign bus.PC2_IDEX      = idex_q.pc2;
  assign bus.rsData_IDEX   = idex_q.rs_data;
  assign bus.rtData_IDEX   = idex_q.rt_data;
  assign bus.imm_IDEX      = idex_q.imm;
  assign bus.opcode_IDEX   = idex_q.opcode;
  assign bus.writeReg_IDEX = idex_q.write_reg;
  assign bus.regWrite_IDEX = idex_q.reg_write;
  assign bus.memRead_IDEX  = idex_q.mem_read;
  assign bus.memWrite_IDEX = idex_q.mem_write;
  assign bus.halt_IDEX     = idex_q.halt;

endmodule

// File: tb/tb_decode.sv
// Bench for decode: table of per-cycle vectors with hand-derived decode results,
// a register-file model for operands, and an expected ID/EX queue.
module tb_decode;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  decode_if bus ();
  decode dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [15:0] instr;
    logic        halt;
    logic        tb;
    logic        frz;
    logic        wben;
    logic [2:0]  wbreg;
    logic [15:0] wbdata;
    logic        e_stall;
    logic        e_start;
    logic [15:0] e_imm;
    logic [2:0]  e_wr;
    logic        e_rw;
    logic        e_mr;
    logic        e_mw;
  } vec_t;

  vec_t        tbl[$];
  logic [91:0] exp_q[$];
  logic [91:0] cur;
  logic [91:0] bubble;
  logic [15:0] m_rf [8];
  int          n_vec = 0;
  int          n_err = 0;

  function automatic logic [91:0] pk(logic [15:0] pc, logic [15:0] pc2, logic [15:0] rsd,
                                     logic [15:0] rtd, logic [15:0] imm, logic [4:0] op,
                                     logic [2:0] wr, logic rw, logic mr, logic mw, logic h);
    return {pc, pc2, rsd, rtd, imm, op, wr, rw, mr, mw, h};
  endfunction

  function automatic vec_t mk(logic [15:0] instr, logic halt, logic tb, logic frz,
                              logic wben, logic [2:0] wbreg, logic [15:0] wbdata,
                              logic e_stall, logic e_start, logic [15:0] e_imm,
                              logic [2:0] e_wr, logic e_rw, logic e_mr, logic e_mw);
    vec_t v;
    v.instr = instr; v.halt = halt; v.tb = tb; v.frz = frz;
    v.wben = wben; v.wbreg = wbreg; v.wbdata = wbdata;
    v.e_stall = e_stall; v.e_start = e_start; v.e_imm = e_imm;
    v.e_wr = e_wr; v.e_rw = e_rw; v.e_mr = e_mr; v.e_mw = e_mw;
    return v;
  endfunction

  function automatic logic [91:0] dut_idex();
    return pk(bus.PC_IDEX, bus.PC2_IDEX, bus.rsData_IDEX, bus.rtData_IDEX, bus.imm_IDEX,
              bus.opcode_IDEX, bus.writeReg_IDEX, bus.regWrite_IDEX, bus.memRead_IDEX,
              bus.memWrite_IDEX, bus.halt_IDEX);
  endfunction

  task automatic chk(input string name, input logic [91:0] got, input logic [91:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // One cycle: drive at negedge, check stall outputs, predict ID/EX, check after the edge.
  task automatic apply(input vec_t v, input logic [15:0] pc);
    logic [15:0] rsv, rtv;
    logic [91:0] e;
    bus.instr_IFID       = v.instr;
    bus.PC_IFID          = pc;
    bus.PC2_IFID         = pc + 16'd2;
    bus.halt_IFID        = v.halt;
    bus.takeBranch_EXMEM = v.tb;
    bus.freeze           = v.frz;
    bus.wbEn             = v.wben;
    bus.wbReg            = v.wbreg;
    bus.wbData           = v.wbdata;
    #1;
    chk("stallCtrl", {91'd0, bus.stallCtrl}, {91'd0, v.e_stall});
    chk("startStall", {91'd0, bus.startStall}, {91'd0, v.e_start});
    rsv = (v.wben && v.wbreg == v.instr[10:8]) ? v.wbdata : m_rf[v.instr[10:8]];
    rtv = (v.wben && v.wbreg == v.instr[7:5])  ? v.wbdata : m_rf[v.instr[7:5]];
    if (v.frz) begin
      if (v.tb || v.e_stall) cur = bubble;
      else cur = pk(pc, pc + 16'd2, rsv, rtv, v.e_imm, v.instr[15:11], v.e_wr,
                    v.e_rw, v.e_mr, v.e_mw, v.halt);
      if (v.wben) m_rf[v.wbreg] = v.wbdata;
    end
    exp_q.push_back(cur);
    @(posedge clk);
    @(negedge clk);
    e = exp_q.pop_front();
    chk("idex", dut_idex(), e);
  endtask

  initial begin
    bubble = pk(16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 5'b00001, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) m_rf[i] = 16'h0000;
    cur = bubble;

    //      instr     h  tb fz we wr    wdata     st ss imm       wr  rw mr mw
    tbl.push_back(mk(16'h0800, 0, 0, 1, 1, 3'd1, 16'h1111, 0, 0, 16'h0000, 3'd0, 0, 0, 0));
    tbl.push_back(mk(16'h0800, 0, 0, 1, 1, 3'd2, 16'h2222, 0, 0, 16'h0000, 3'd0, 0, 0, 0));
    tbl.push_back(mk(16'hDB94, 0, 0, 1, 1, 3'd3, 16'hBEEF, 0, 0, 16'h0000, 3'd5, 1, 0, 0));
    tbl.push_back(mk(16'h415F, 0, 0, 1, 0, 3'd0, 16'h0000, 0, 0, 16'hFFFF, 3'd2, 1, 0, 0));
    tbl.push_back(mk(16'h515F, 0, 0, 1, 0, 3'd0, 16'h0000, 0, 0, 16'h001F, 3'd2, 1, 0, 0));
    tbl.push_back(mk(16'h3400, 0, 0, 1, 0, 3'd0, 16'h0000, 0, 0, 16'hFC00, 3'd7, 1, 0, 0));
    tbl.push_back(mk(16'h23FF, 0, 0, 1, 0, 3'd0, 16'h0000, 0, 0, 16'h03FF, 3'd0, 0, 0, 0));
    tbl.push_back(mk(16'h8150, 0, 0, 1, 0, 3'd0, 16'h0000, 0, 0, 16'hFFF0, 3'd0, 0, 0, 1));
    tbl.push_back(mk(16'h6280, 0, 0, 1, 0, 3'd0, 16'h0000, 0, 0, 16'hFF80, 3'd0, 0, 0, 0));
    tbl.push_back(mk(16'hC57F, 0, 0, 1, 0, 3'd0, 16'h0000, 0, 0, 16'h007F, 3'd5, 1, 0, 0));
    tbl.push_back(mk(16'hAA6F, 0, 0, 1, 0, 3'd0, 16'h0000, 0, 0, 16'h000F, 3'd3, 1, 0, 0));
    tbl.push_back(mk(16'h0000, 1, 0, 1, 0, 3'd0, 16'h0000, 0, 0, 16'h0000, 3'd0, 0, 0, 0));
    // load-use on Rs: one stall cycle, then the ADD goes through
    tbl.push_back(mk(16'h8944, 0, 0, 1, 0, 3'd0, 16'h0000, 0, 0, 16'h0004, 3'd2, 1, 1, 0));
    tbl.push_back(mk(16'hDA2C, 0, 0, 1, 0, 3'd0, 16'h0000, 1, 1, 16'h0000, 3'd3, 1, 0, 0));
    tbl.push_back(mk(16'hDA2C, 0, 0, 1, 0, 3'd0, 16'h0000, 0, 0, 16'h0000, 3'd3, 1, 0, 0));
    // load-use on Rt via a store
    tbl.push_back(mk(16'h8944, 0, 0, 1, 0, 3'd0, 16'h0000, 0, 0, 16'h0004, 3'd2, 1, 1, 0));
    tbl.push_back(mk(16'h8140, 0, 0, 1, 0, 3'd0, 16'h0000, 1, 1, 16'h0000, 3'd0, 0, 0, 1));
    tbl.push_back(mk(16'h8140, 0, 0, 1, 0, 3'd0, 16'h0000, 0, 0, 16'h0000, 3'd0, 0, 0, 1));
    // flush together with a hazard and halt
    tbl.push_back(mk(16'h8944, 0, 0, 1, 0, 3'd0, 16'h0000, 0, 0, 16'h0004, 3'd2, 1, 1, 0));
    tbl.push_back(mk(16'hDA2C, 1, 1, 1, 0, 3'd0, 16'h0000, 0, 0, 16'h0000, 3'd3, 1, 0, 0));
    // LBI names R2 in Rs but does not read it: no stall
    tbl.push_back(mk(16'h8944, 0, 0, 1, 0, 3'd0, 16'h0000, 0, 0, 16'h0004, 3'd2, 1, 1, 0));
    tbl.push_back(mk(16'hC201, 0, 0, 1, 0, 3'd0, 16'h0000, 0, 0, 16'h0001, 3'd2, 1, 0, 0));
    // hazard while frozen: stall stays asserted, nothing moves, no RF write
    tbl.push_back(mk(16'h8944, 0, 0, 1, 0, 3'd0, 16'h0000, 0, 0, 16'h0004, 3'd2, 1, 1, 0));
    tbl.push_back(mk(16'hDA2C, 0, 0, 0, 1, 3'd5, 16'h5555, 1, 1, 16'h0000, 3'd3, 1, 0, 0));
    tbl.push_back(mk(16'hDA2C, 0, 0, 0, 1, 3'd6, 16'h6666, 1, 1, 16'h0000, 3'd3, 1, 0, 0));
    tbl.push_back(mk(16'hDA2C, 0, 0, 1, 0, 3'd0, 16'h0000, 1, 1, 16'h0000, 3'd3, 1, 0, 0));
    tbl.push_back(mk(16'hDA2C, 0, 0, 1, 0, 3'd0, 16'h0000, 0, 0, 16'h0000, 3'd3, 1, 0, 0));
    tbl.push_back(mk(16'hDDC0, 0, 0, 1, 0, 3'd0, 16'h0000, 0, 0, 16'h0000, 3'd0, 1, 0, 0));
    // freeze for 3 cycles with changing IF/ID and write-backs
    tbl.push_back(mk(16'h415F, 0, 0, 0, 1, 3'd5, 16'h1234, 0, 0, 16'hFFFF, 3'd2, 1, 0, 0));
    tbl.push_back(mk(16'h515F, 0, 0, 0, 1, 3'd6, 16'h4321, 0, 0, 16'h001F, 3'd2, 1, 0, 0));
    tbl.push_back(mk(16'h3400, 0, 0, 0, 1, 3'd5, 16'h9999, 0, 0, 16'hFC00, 3'd7, 1, 0, 0));
    tbl.push_back(mk(16'hDDC0, 0, 0, 1, 0, 3'd0, 16'h0000, 0, 0, 16'h0000, 3'd0, 1, 0, 0));
    // R0 is an ordinary register
    tbl.push_back(mk(16'h0800, 0, 0, 1, 1, 3'd0, 16'hA5A5, 0, 0, 16'h0000, 3'd0, 0, 0, 0));
    tbl.push_back(mk(16'hD800, 0, 0, 1, 0, 3'd0, 16'h0000, 0, 0, 16'h0000, 3'd0, 1, 0, 0));

    // reset held for two cycles
    rst                  = 1'b1;
    bus.instr_IFID       = 16'h0800;
    bus.PC_IFID          = 16'h0000;
    bus.PC2_IFID         = 16'h0002;
    bus.halt_IFID        = 1'b0;
    bus.takeBranch_EXMEM = 1'b0;
    bus.freeze           = 1'b1;
    bus.wbEn             = 1'b0;
    bus.wbReg            = 3'd0;
    bus.wbData           = 16'h0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_idex", dut_idex(), bubble);
    chk("reset_stall", {91'd0, bus.stallCtrl}, 92'd0);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], 16'h0040 + 16'(2 * i));

    // reset while frozen still clears ID/EX and the register file
    rst                  = 1'b1;
    bus.freeze           = 1'b0;
    bus.instr_IFID       = 16'hDA2C;
    @(posedge clk);
    @(negedge clk);
    chk("frozen_reset_idex", dut_idex(), bubble);
    chk("frozen_reset_stall", {91'd0, bus.stallCtrl}, 92'd0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) m_rf[i] = 16'h0000;
    cur = bubble;
    apply(mk(16'hD800, 0, 0, 1, 0, 3'd0, 16'h0000, 0, 0, 16'h0000, 3'd0, 1, 0, 0), 16'h0200);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
